// File: rtl/afe_pkg.sv
// Shared constants and types for the AFE command sequencer slice.
package afe_pkg;

  localparam int unsigned CMD_W          = 20;
  localparam int unsigned ADDR_W_DEF     = 6;
  localparam int unsigned NUM_INIT_DEF   = 16;
  localparam int unsigned GAP_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 64;

  typedef logic [CMD_W-1:0] afe_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } seq_state_e;

endpackage

// File: rtl/afe_cmd_sequencer_if.sv
// Link between the sequencer (master) and afe_serial_out (slave).
interface afe_cmd_sequencer_if;
  import afe_pkg::*;

  logic     afe_enable;
  logic     afe_start;
  afe_cmd_t afe_cmd;
  logic     afe_done;

  modport master (output afe_enable, output afe_start, output afe_cmd, input afe_done);
  modport slave  (input afe_enable, input afe_start, input afe_cmd, output afe_done);

endinterface

// File: rtl/afe_watchdog.sv
// Per-wait-state timeout counter; expired_c flags the TIMEOUT-th clock spent waiting.
module afe_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_c = run && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expired_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/afe_cmd_sequencer.sv
// Replays the init command table into afe_serial_out after init_start, then serves host writes.
module afe_cmd_sequencer
  import afe_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned NUM_INIT   = NUM_INIT_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                init_start,
  output logic [ADDR_W-1:0]   rom_addr,
  input  afe_cmd_t            rom_data,
  input  logic                host_req,
  input  afe_cmd_t            host_data,
  output logic                host_ack,
  output logic                init_done,
  output logic                busy,
  output logic                error,
  afe_cmd_sequencer_if.master afe
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              is_host_q, is_host_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  afe_cmd_t          cmd_q, cmd_d;
  logic              start_q, start_d;
  logic              enable_q, enable_d;
  logic              host_ack_q, host_ack_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic wd_clear_c, wd_run_c, wd_expired_c, gap_done_c;

  afe_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear     (wd_clear_c),
    .run       (wd_run_c),
    .expired_c (wd_expired_c)
  );

  assign wd_run_c   = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign gap_done_c = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    is_host_d   = is_host_q;
    rom_addr_d  = rom_addr_q;
    cmd_d       = cmd_q;
    host_ack_d  = 1'b0;
    init_done_d = init_done_q;
    error_d     = error_q;
    wd_clear_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d     = ST_FETCH;
          idx_d       = '0;
          rom_addr_d  = '0;
          is_host_d   = 1'b0;
          init_done_d = 1'b0;
          error_d     = 1'b0;
        end else if (host_req && init_done_q && !host_ack_q) begin
          state_d   = ST_ISSUE;
          cmd_d     = host_data;
          is_host_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        cmd_d   = rom_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT_BUSY;
        wd_clear_c = 1'b1;
      end
      ST_WAIT_BUSY: begin
        if (wd_expired_c) begin
          error_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (!afe.afe_done) begin
          state_d    = ST_WAIT_DONE;
          wd_clear_c = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (afe.afe_done) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (wd_expired_c) begin
          error_d   = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!gap_done_c) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (is_host_q) begin
          host_ack_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (idx_q == LAST_IDX) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = ADDR_W'(idx_q + IDX_W'(1));
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_d  = (state_d == ST_ISSUE);
    enable_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_BUSY) || (state_d == ST_WAIT_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      is_host_q   <= 1'b0;
      rom_addr_q  <= '0;
      cmd_q       <= '0;
      start_q     <= 1'b0;
      enable_q    <= 1'b0;
      host_ack_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      is_host_q   <= is_host_d;
      rom_addr_q  <= rom_addr_d;
      cmd_q       <= cmd_d;
      start_q     <= start_d;
      enable_q    <= enable_d;
      host_ack_q  <= host_ack_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign host_ack       = host_ack_q;
  assign init_done      = init_done_q;
  assign busy           = busy_q;
  assign error          = error_q;
  assign afe.afe_enable = enable_q;
  assign afe.afe_start  = start_q;
  assign afe.afe_cmd    = cmd_q;

endmodule

// File: tb/tb_afe_cmd_sequencer.sv
// Sequencer paired with a behavioural afe_serial_out, a 1-clk-latency ROM and a MOSI frame monitor.
module tb_afe_cmd_sequencer;
  import afe_pkg::*;

  localparam int unsigned GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        init_start;
  logic [5:0]  rom_addr;
  afe_cmd_t    rom_data;
  logic        host_req;
  afe_cmd_t    host_data;
  logic        host_ack;
  logic        init_done;
  logic        busy;
  logic        error;
  logic        stuck;

  afe_cmd_sequencer_if afe_if ();

  afe_cmd_sequencer dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .init_start (init_start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .host_req   (host_req),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .init_done  (init_done),
    .busy       (busy),
    .error      (error),
    .afe        (afe_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM holding 0x00001..0x00040, read latency one clock
  afe_cmd_t rom_mem [0:63];
  initial for (int i = 0; i < 64; i++) rom_mem[i] = CMD_W'(i + 1);
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // afe_serial_out model: MSB-first, one bit per clock, done low while shifting
  logic     m_busy, m_done_q, cs_n, mosi;
  afe_cmd_t m_sh;
  int       m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done_q <= 1'b1; cs_n <= 1'b1; m_sh <= '0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (afe_if.afe_enable && afe_if.afe_start) begin
        m_sh <= afe_if.afe_cmd; m_cnt <= 0; m_busy <= 1'b1; m_done_q <= 1'b0; cs_n <= 1'b0;
      end
    end else begin
      m_sh  <= {m_sh[CMD_W-2:0], 1'b0};
      m_cnt <= m_cnt + 1;
      if (m_cnt == CMD_W - 1) begin
        m_busy <= 1'b0; cs_n <= 1'b1; m_done_q <= 1'b1;
      end
    end
  end
  assign mosi = m_sh[CMD_W-1];
  assign afe_if.afe_done = stuck ? 1'b0 : m_done_q;

  // MOSI frame decoder and inter-frame idle measurement
  afe_cmd_t rx;
  int       mon_bits = 0;
  int       mon_gap = 0;
  int       n_frames = 0;
  int       min_gap = 1000;
  afe_cmd_t frames[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits <= 0; mon_gap <= 0;
    end else if (!cs_n) begin
      rx       <= {rx[CMD_W-2:0], mosi};
      mon_bits <= mon_bits + 1;
      if (mon_bits == 0 && n_frames > 0 && mon_gap < min_gap) min_gap <= mon_gap;
      mon_gap  <= 0;
    end else begin
      if (mon_bits == CMD_W) begin
        frames.push_back(rx);
        n_frames <= n_frames + 1;
      end
      mon_bits <= 0;
      mon_gap  <= mon_gap + 1;
    end
  end

  int ack_cnt = 0;
  always @(posedge clk) if (host_ack) ack_cnt <= ack_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"},  32'(rom_addr), 32'h0);
    check({tag, "_afe_cmd"},   32'(afe_if.afe_cmd), 32'h0);
    check({tag, "_afe_start"}, 32'(afe_if.afe_start), 32'h0);
    check({tag, "_afe_en"},    32'(afe_if.afe_enable), 32'h0);
    check({tag, "_host_ack"},  32'(host_ack), 32'h0);
    check({tag, "_init_done"}, 32'(init_done), 32'h0);
    check({tag, "_busy"},      32'(busy), 32'h0);
    check({tag, "_error"},     32'(error), 32'h0);
  endtask

  task automatic check_init_frames(input int base);
    for (int i = 0; i < 16; i++)
      check($sformatf("init_frame%0d", i), 32'(frames[base + i]), 32'(i + 1));
  endtask

  task automatic wait_init_done(input string tag);
    int n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_init_done"}, 32'(init_done), 32'h1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!host_ack && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ack"}, 32'(host_ack), 32'h1);
    check({tag, "_idle_at_ack"}, 32'(busy), 32'h0);
    host_req = 1'b0;
  endtask

  task automatic pulse_init();
    @(negedge clk); init_start = 1'b1;
    @(posedge clk); #1; init_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  int base;
  int acks0;
  int n;

  initial begin
    rst_n = 1'b0; init_start = 1'b0; host_req = 1'b0; host_data = '0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // init_start and host_req together: init table runs first, host served after
    repeat (2) @(negedge clk);
    base = frames.size(); acks0 = ack_cnt;
    init_start = 1'b1; host_req = 1'b1; host_data = 20'h12345;
    @(posedge clk); #1; init_start = 1'b0;
    check("fetch_rom_addr", 32'(rom_addr), 32'h0);
    check("fetch_no_start", 32'(afe_if.afe_start), 32'h0);
    check("fetch_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    check("latch_no_start", 32'(afe_if.afe_start), 32'h0);
    @(posedge clk); #1;
    check("init_start_latency", 32'(afe_if.afe_start), 32'h1);
    check("first_cmd", 32'(afe_if.afe_cmd), 32'h1);
    check("issue_enable", 32'(afe_if.afe_enable), 32'h1);
    @(posedge clk); #1;
    check("start_one_clk", 32'(afe_if.afe_start), 32'h0);
    wait_init_done("init1");
    check("init1_frames_at_done", 32'(frames.size() - base), 32'd16);
    check("host_not_acked_early", 32'(ack_cnt - acks0), 32'd0);
    wait_ack("held_host");
    check("init1_frame_total", 32'(frames.size() - base), 32'd17);
    check_init_frames(base);
    check("host_after_init", 32'(frames[base + 16]), 32'h12345);
    check("min_gap", 32'(min_gap >= GAP), 32'h1);

    // host write with init_done set: 1-clk latency, single ack
    repeat (3) @(negedge clk);
    base = frames.size(); acks0 = ack_cnt;
    host_req = 1'b1; host_data = 20'hA5A5A;
    @(posedge clk); #1;
    check("host_latency", 32'(afe_if.afe_start), 32'h1);
    check("host_cmd", 32'(afe_if.afe_cmd), 32'hA5A5A);
    wait_ack("host");
    repeat (4) @(posedge clk);
    #1;
    check("host_single_ack", 32'(ack_cnt - acks0), 32'd1);
    check("host_frame", 32'(frames[base]), 32'hA5A5A);
    check("host_busy_after", 32'(busy), 32'h0);

    // init_start during a host transfer is ignored
    @(negedge clk);
    base = frames.size();
    host_req = 1'b1; host_data = 20'h0BEEF;
    repeat (6) @(posedge clk);
    @(negedge clk); init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
    wait_ack("host_ign");
    repeat (40) @(posedge clk);
    #1;
    check("ign_init_done", 32'(init_done), 32'h1);
    check("ign_frame_count", 32'(frames.size() - base), 32'd1);
    check("ign_frame", 32'(frames[base]), 32'h0BEEF);
    check("ign_busy", 32'(busy), 32'h0);

    // stuck afe_done: watchdog flags error, sequence continues
    stuck = 1'b1;
    base = frames.size();
    pulse_init();
    check("stuck_init_done_clr", 32'(init_done), 32'h0);
    n = 0;
    while (!afe_if.afe_start && n < 20) begin @(posedge clk); #1; n++; end
    check("stuck_start_seen", 32'(afe_if.afe_start), 32'h1);
    n = 0;
    while (!error && n < 200) begin @(posedge clk); #1; n++; end
    check("wd_latency", 32'(n), 32'd66);
    stuck = 1'b0;
    wait_init_done("stuck");
    check("stuck_error_sticky", 32'(error), 32'h1);
    check("stuck_frame_count", 32'(frames.size() - base), 32'd16);
    check_init_frames(base);

    // init_start clears error; reset mid-frame at bit 10
    pulse_init();
    check("reinit_error_clr", 32'(error), 32'h0);
    check("reinit_done_clr", 32'(init_done), 32'h0);
    n = 0;
    while (mon_bits != 10 && n < 200) begin @(negedge clk); #1; n++; end
    check("midframe_bit10", 32'(mon_bits), 32'd10);
    check("midframe_enable", 32'(afe_if.afe_enable), 32'h1);
    #1; rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_cs", 32'(cs_n), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = frames.size();
    pulse_init();
    wait_init_done("post_reset");
    check("post_reset_frames", 32'(frames.size() - base), 32'd16);
    check_init_frames(base);
    check("post_reset_error", 32'(error), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(busy), 32'h0);
    check("final_min_gap", 32'(min_gap >= GAP), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
